// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared constants and helpers for the rate-1/2, K=3 Viterbi decoder
// (generators 7,5 octal).
//   NSTATES      number of trellis states ({s1,s0}, s1 = newest past bit)
//   K            constraint length
//   G1, G2       generator taps applied to {u,s1,s0}
//   PM_INIT      starting metric of the three non-zero states
//   expected_sym code symbol {g1,g2} emitted when bit u leaves a given state
package decoder_pkg;

    localparam int NSTATES = 4;
    localparam int K       = 3;

    localparam logic [2:0] G1 = 3'b111;
    localparam logic [2:0] G2 = 3'b101;

    localparam int PM_INIT = 16;

    function automatic logic [1:0] expected_sym(input logic [1:0] state, input logic u);
        logic [2:0] w_reg;
        w_reg = {u, state};
        return {^(w_reg & G1), ^(w_reg & G2)};
    endfunction

endpackage

// File: rtl/decoder_acs.sv
// decoder_acs
// One add-compare-select unit. Adds each candidate's branch metric to its
// predecessor path metric (saturating at 2^PM_W-1) and keeps the smaller.
//   i_pm_a / i_bm_a  path and branch metric via the lower-index predecessor
//   i_pm_b / i_bm_b  path and branch metric via the higher-index predecessor
//   o_pm             surviving (un-normalized) path metric
//   o_dec            1 when the higher-index predecessor survives
module decoder_acs #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] i_pm_a,
    input  logic [PM_W-1:0] i_pm_b,
    input  logic [1:0]      i_bm_a,
    input  logic [1:0]      i_bm_b,
    output logic [PM_W-1:0] o_pm,
    output logic            o_dec
);

    localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

    logic [PM_W:0]   w_sum_a;
    logic [PM_W:0]   w_sum_b;
    logic [PM_W-1:0] w_cand_a;
    logic [PM_W-1:0] w_cand_b;

    // One spare bit catches the carry so the sum can clamp instead of wrapping
    assign w_sum_a = {1'b0, i_pm_a} + {{(PM_W-1){1'b0}}, i_bm_a};
    assign w_sum_b = {1'b0, i_pm_b} + {{(PM_W-1){1'b0}}, i_bm_b};

    assign w_cand_a = w_sum_a[PM_W] ? PM_MAX : w_sum_a[PM_W-1:0];
    assign w_cand_b = w_sum_b[PM_W] ? PM_MAX : w_sum_b[PM_W-1:0];

    // Strict compare: a tie keeps the lower-index predecessor
    assign o_dec = (w_cand_b < w_cand_a);
    assign o_pm  = o_dec ? w_cand_b : w_cand_a;

endmodule

// File: rtl/decoder.sv
// decoder
// Hard-decision Viterbi decoder, rate 1/2, K=3, generators 7,5 octal, with
// register-exchange survivor memory. One decoded bit leaves per accepted
// symbol after a TB_DEPTH-symbol delay.
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   in_valid  qualifies in
//   in        code symbol {g1,g2}
//   o         decoded bit (registered)
//   enable    high once o carries decoded data, held until reset
//   err_cnt   (only with DECODER_ERR_CNT_EN) running estimate of corrected
//             channel bit errors, saturating at 16'hFFFF
// Optional feature macro: DECODER_ERR_CNT_EN
module decoder
    import decoder_pkg::*;
#(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] in,
    output logic       o,
    output logic       enable
`ifdef DECODER_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);
    localparam logic [PM_W-1:0]  PM_MAX   = {PM_W{1'b1}};
    localparam logic [PM_W-1:0]  PM_START = (PM_INIT > (2**PM_W - 1)) ? PM_MAX : PM_W'(PM_INIT);

    logic [PM_W-1:0]     r_pm   [NSTATES];
    logic [TB_DEPTH-1:0] r_surv [NSTATES];
    logic [CNT_W-1:0]    r_cnt;
    logic                r_o;
    logic                r_enable;

    logic [PM_W-1:0]     w_pm_new   [NSTATES];
    logic                w_dec      [NSTATES];
    logic [TB_DEPTH-1:0] w_surv_new [NSTATES];
    logic [PM_W-1:0]     w_min;
    logic [1:0]          w_best;

    // Next state ns = {u,s1}: both predecessors share s1 = ns[0], and the
    // input bit that led here is ns[1]
    for (genvar ns = 0; ns < NSTATES; ns++) begin : g_acs
        localparam logic [1:0] NS     = 2'(ns);
        localparam logic [1:0] PRED_A = {NS[0], 1'b0};
        localparam logic [1:0] PRED_B = {NS[0], 1'b1};

        logic [1:0]          w_xa;
        logic [1:0]          w_xb;
        logic [1:0]          w_bm_a;
        logic [1:0]          w_bm_b;
        logic [TB_DEPTH-1:0] w_surv_sel;

        assign w_xa   = in ^ expected_sym(PRED_A, NS[1]);
        assign w_xb   = in ^ expected_sym(PRED_B, NS[1]);
        assign w_bm_a = {1'b0, w_xa[1]} + {1'b0, w_xa[0]};
        assign w_bm_b = {1'b0, w_xb[1]} + {1'b0, w_xb[0]};

        decoder_acs #(.PM_W(PM_W)) u_acs (
            .i_pm_a (r_pm[PRED_A]),
            .i_pm_b (r_pm[PRED_B]),
            .i_bm_a (w_bm_a),
            .i_bm_b (w_bm_b),
            .o_pm   (w_pm_new[ns]),
            .o_dec  (w_dec[ns])
        );

        assign w_surv_sel     = w_dec[ns] ? r_surv[PRED_B] : r_surv[PRED_A];
        assign w_surv_new[ns] = {w_surv_sel[TB_DEPTH-2:0], NS[1]};
    end

    // Smallest new metric doubles as the normalization amount; strict compare
    // makes the lowest state index win ties for the best-state pick
    always_comb begin
        w_min  = w_pm_new[0];
        w_best = 2'd0;
        for (int s = 1; s < NSTATES; s++) begin
            if (w_pm_new[s] < w_min) begin
                w_min  = w_pm_new[s];
                w_best = 2'(s);
            end
        end
    end

    // Trellis update. o only starts following the best survivor once that
    // survivor is fully populated with real decisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pm[0] <= '0;
            for (int s = 1; s < NSTATES; s++) begin
                r_pm[s] <= PM_START;
            end
            for (int s = 0; s < NSTATES; s++) begin
                r_surv[s] <= '0;
            end
            r_cnt    <= '0;
            r_o      <= 1'b0;
            r_enable <= 1'b0;
        end else if (in_valid) begin
            for (int s = 0; s < NSTATES; s++) begin
                r_pm[s]   <= w_pm_new[s] - w_min;
                r_surv[s] <= w_surv_new[s];
            end
            if (r_cnt != CNT_FULL) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt >= CNT_LAST) begin
                r_o      <= w_surv_new[w_best][TB_DEPTH-1];
                r_enable <= 1'b1;
            end
        end
    end

    assign o      = r_o;
    assign enable = r_enable;

`ifdef DECODER_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic [16:0] w_err_sum;

    assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_min);

    // The total removed by normalization equals the best path's distance
    // from the received stream, i.e. the number of bits it had to correct
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (in_valid) begin
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_decoder.sv
// tb_decoder
// Directed bench for the K=3 (7,5) Viterbi decoder with default parameters
// (TB_DEPTH=15). Message 1,0,1,1,0,0 encodes to 11 10 00 01 01 11, then 00s.
module tb_decoder;

    localparam int DEPTH = 15;
    localparam int NSYM  = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_sym;
    logic       o;
    logic       enable;
`ifdef DECODER_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] cleanSyms [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic       msgBits   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    decoder dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in       (in_sym),
        .o        (o),
        .enable   (enable)
`ifdef DECODER_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    function automatic logic [1:0] cleanSym(input int i);
        if (i < 6) return cleanSyms[i];
        return 2'b00;
    endfunction

    // Decoded bit expected on o right after symbol i has been accepted
    function automatic logic expBit(input int i);
        int k;
        k = i - (DEPTH - 1);
        if (k >= 0 && k < 6) return msgBits[k];
        return 1'b0;
    endfunction

    task automatic applyStimulus(input logic [1:0] sym);
        in_valid = 1'b1;
        in_sym   = sym;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_sym   = 2'b11;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_o got=%b expected=0", o);
        end
        checks++;
        if (enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_enable got=%b expected=0", enable);
        end
`ifdef DECODER_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_err_cnt got=%0d expected=0", err_cnt);
        end
`endif
    endtask

    task automatic test_all_zero();
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(2'b00);
            checks++;
            if (enable !== (i >= DEPTH - 1)) begin
                errors++;
                $display("[TB] FAIL zero_enable sym=%0d got=%b expected=%b", i, enable, (i >= DEPTH - 1));
            end
            checks++;
            if (o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_o sym=%0d got=%b expected=0", i, o);
            end
        end
`ifdef DECODER_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL zero_err_cnt got=%0d expected=0", err_cnt);
        end
`endif
    endtask

    task automatic test_clean_message();
        doReset();
        for (int i = 0; i < NSYM; i++) begin
            applyStimulus(cleanSym(i));
            checks++;
            if (enable !== (i >= DEPTH - 1)) begin
                errors++;
                $display("[TB] FAIL clean_enable sym=%0d got=%b expected=%b", i, enable, (i >= DEPTH - 1));
            end
            checks++;
            if (o !== expBit(i)) begin
                errors++;
                $display("[TB] FAIL clean_o sym=%0d got=%b expected=%b", i, o, expBit(i));
            end
        end
`ifdef DECODER_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL clean_err_cnt got=%0d expected=0", err_cnt);
        end
`endif
    endtask

    task automatic test_single_error();
        doReset();
        for (int i = 0; i < NSYM; i++) begin
            applyStimulus((i == 2) ? 2'b10 : cleanSym(i));
            checks++;
            if (o !== expBit(i)) begin
                errors++;
                $display("[TB] FAIL err1_o sym=%0d got=%b expected=%b", i, o, expBit(i));
            end
        end
`ifdef DECODER_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL err1_err_cnt got=%0d expected=1", err_cnt);
        end
`endif
    endtask

    task automatic test_two_errors();
        logic [1:0] sym;
        doReset();
        for (int i = 0; i < NSYM; i++) begin
            sym = (i == 1) ? 2'b01 : ((i == 11) ? 2'b10 : 2'b00);
            applyStimulus(sym);
            checks++;
            if (o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL err2_o sym=%0d got=%b expected=0", i, o);
            end
        end
`ifdef DECODER_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL err2_err_cnt got=%0d expected=2", err_cnt);
        end
`endif
    endtask

    task automatic test_gaps();
        logic oHold;
        logic enHold;
        doReset();
        for (int i = 0; i < NSYM; i++) begin
            applyStimulus(cleanSym(i));
            checks++;
            if (o !== expBit(i) || enable !== (i >= DEPTH - 1)) begin
                errors++;
                $display("[TB] FAIL gap_decode sym=%0d got o=%b en=%b expected o=%b en=%b",
                         i, o, enable, expBit(i), (i >= DEPTH - 1));
            end
            oHold  = o;
            enHold = enable;
            for (int g = 0; g < (i % 3); g++) begin
                in_sym = ~in_sym;
                @(posedge clk);
                #1;
                checks++;
                if (o !== oHold || enable !== enHold) begin
                    errors++;
                    $display("[TB] FAIL gap_hold sym=%0d gap=%0d got o=%b en=%b expected o=%b en=%b",
                             i, g, o, enable, oHold, enHold);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(cleanSym(i));
        end
        checks++;
        if (enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pre_enable got=%b expected=1", enable);
        end
        doReset();
        checks++;
        if (enable !== 1'b0 || o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_drop got en=%b o=%b expected en=0 o=0", enable, o);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(cleanSym(i));
        end
        doReset();
        for (int i = 0; i < NSYM; i++) begin
            applyStimulus(cleanSym(i));
            checks++;
            if (enable !== (i >= DEPTH - 1) || o !== expBit(i)) begin
                errors++;
                $display("[TB] FAIL midrst_replay sym=%0d got en=%b o=%b expected en=%b o=%b",
                         i, enable, o, (i >= DEPTH - 1), expBit(i));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sym   = 2'b00;
        test_reset();
        test_all_zero();
        test_clean_message();
        test_single_error();
        test_two_errors();
        test_gaps();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
